// File: rtl/ram_access_arbiter.sv
// Two-requester round-robin front end for a single-port RAM with registered reads,
// plus a sweep sequencer that reads every word in address order.
module ram_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_valid,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_done,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              rr_last;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;
  logic              last_word;

  assign last_word  = (cnt == {ADDR_W{1'b1}});
  assign sweep_busy = (state == SWEEP);
  assign rdata      = ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (sweep_start) state_nxt = SWEEP;
      SWEEP: if (last_word)   state_nxt = IDLE;
    endcase
  end

  // Issue stage: grant and RAM command are combinational in the request cycle
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ram_wr_en = 1'b0;
    ram_addr  = addr_hold;
    ram_wdata = wdata_hold;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            gnt0 = rr_last;
            gnt1 = ~rr_last;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
          if (gnt0) begin
            ram_addr  = addr0;
            ram_wr_en = we0;
            if (we0) ram_wdata = wdata0;
          end else if (gnt1) begin
            ram_addr  = addr1;
            ram_wr_en = we1;
            if (we1) ram_wdata = wdata1;
          end
        end
        SWEEP: ram_addr = cnt;
      endcase
    end
  end

  // Idle cycles keep the RAM address/data buses steady at their last value
  always_ff @(posedge clk) begin
    addr_hold  <= ram_addr;
    wdata_hold <= ram_wdata;
  end

  // Return stage: tags line up with the RAM's one-cycle read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last     <= 1'b1;
      cnt         <= '0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      sweep_valid <= 1'b0;
      sweep_addr  <= '0;
      sweep_done  <= 1'b0;
    end else begin
      if (gnt0)      rr_last <= 1'b0;
      else if (gnt1) rr_last <= 1'b1;

      if (state == IDLE && sweep_start) cnt <= '0;
      else if (state == SWEEP)          cnt <= cnt + ADDR_W'(1);

      rvalid0     <= gnt0 && !we0;
      rvalid1     <= gnt1 && !we1;
      sweep_valid <= (state == SWEEP);
      if (state == SWEEP) sweep_addr <= cnt;
      sweep_done  <= (state == SWEEP) && last_word;
    end
  end

endmodule
